// File: rtl/exam_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : exam_pkg
//  Description : Shared constants for the button conditioner: FSM state
//                encoding and default timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package exam_pkg;

    // Press-tracking FSM encoding
    localparam logic ST_RELEASED = 1'b0;
    localparam logic ST_PRESSED  = 1'b1;

    // Default debounce timing
    localparam int DEF_SAMPLE_DIV = 8;
    localparam int DEF_DEB_LEN    = 4;

    typedef enum logic {
        RELEASED = ST_RELEASED,
        PRESSED  = ST_PRESSED
    } btn_state_e;

endpackage : exam_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchroniser, free-running sample divider, sample
//                shift register and debounced level register.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import exam_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int DEB_LEN    = DEF_DEB_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic tick
);

    localparam int             CW   = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0]  LAST = CW'(SAMPLE_DIV - 1);

    logic               sync_1;
    logic               btn_s;
    logic [CW-1:0]      div_cnt;
    logic [DEB_LEN-1:0] shreg;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            btn_s  <= sync_1;
        end
    end

    // Free-running divider; never restarted by button activity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = (div_cnt == LAST);

    // Take one sample of the synchronised button per tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (tick) begin
            shreg <= {shreg[DEB_LEN-2:0], btn_s};
        end
    end

    // Level changes only once the whole sample window agrees
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db <= 1'b0;
        end else if (&shreg) begin
            btn_db <= 1'b1;
        end else if (~|shreg) begin
            btn_db <= 1'b0;
        end
    end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/en_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : en_conditioner
//  Description : Turns a bouncy push-button into a one-cycle press pulse and
//                an enable level (toggle mode or follow mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module en_conditioner
    import exam_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int DEB_LEN    = DEF_DEB_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic mode,
    output logic en,
    output logic en_pulse,
    output logic btn_db
);

    btn_state_e state;
    btn_state_e state_next;
    logic       pulse_next;
    logic       unused_tick;

    btn_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEB_LEN    (DEB_LEN)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .tick    (unused_tick)
    );

    // Press-tracking state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RELEASED;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a press is recognised once, on the RELEASED->PRESSED move
    always_comb begin
        state_next = state;
        pulse_next = 1'b0;
        case (state)
            RELEASED: begin
                if (btn_db) begin
                    state_next = PRESSED;
                    pulse_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_db) begin
                    state_next = RELEASED;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase
    end

    // Pulse register and enable level; toggle lands on the pulse edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_pulse <= 1'b0;
            en       <= 1'b0;
        end else begin
            en_pulse <= pulse_next;
            if (mode) begin
                en <= btn_db;
            end else begin
                en <= en ^ pulse_next;
            end
        end
    end

endmodule : en_conditioner
`default_nettype wire

// File: tb/tb_en_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_en_conditioner
//  Description : Directed bench for en_conditioner. Expected press pulses are
//                queued at stimulus time; a monitor pops them as pulses occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_en_conditioner;

    localparam int SD = 8;
    localparam int DL = 4;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic btn_raw = 1'b0;
    logic mode    = 1'b0;
    logic en;
    logic en_pulse;
    logic btn_db;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit en;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    en_conditioner #(
        .SAMPLE_DIV (SD),
        .DEB_LEN    (DL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .mode     (mode),
        .en       (en),
        .en_pulse (en_pulse),
        .btn_db   (btn_db)
    );

    always #5 clk = ~clk;

    // Edges counted since reset release; divider phase is cyc mod SD
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Edge at which the first sample of a change made after edge e is taken
    function automatic int first_shift(input int e);
        int f;
        f = e + 3;
        while (f % SD != 0) f++;
        return f;
    endfunction

    function automatic int db_at(input int e);
        return first_shift(e) + SD * (DL - 1) + 1;
    endfunction

    function automatic int pulse_at(input int e);
        return db_at(e) + 1;
    endfunction

    // Drive point: one time unit after the edge that makes cyc == c
    task automatic hold_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Check point: falling edge after the edge that makes cyc == c
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input bit exp_en, output int e);
        exp_t t;
        btn_raw = 1'b1;
        e       = cyc;
        t.en    = exp_en;
        t.cyc   = pulse_at(e);
        exp_q.push_back(t);
    endtask

    // Monitor: every pulse must match the next queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst && en_pulse) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: en_pulse=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_en", int'(en), int'(e.en));
                check("pulse_btn_db", int'(btn_db), 1);
            end
        end
    end

    initial begin
        int e;
        int p;
        int g;

        // Power-on reset
        #12;
        check("rst_en", int'(en), 0);
        check("rst_en_pulse", int'(en_pulse), 0);
        check("rst_btn_db", int'(btn_db), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        hold_until(20);

        // Clean press in toggle mode: en 0 -> 1
        press(1'b1, e);
        p = pulse_at(e);
        wait_cyc(p - 1);
        check("en_before_toggle", int'(en), 0);
        check("btn_db_before_pulse", int'(btn_db), 1);
        @(posedge clk); #1;
        hold_until(e + 100);
        btn_raw = 1'b0;
        hold_until(cyc + 50);
        check("press1_missing_pulse", exp_q.size(), 0);
        check("press1_en", int'(en), 1);
        check("press1_released_db", int'(btn_db), 0);

        // Second clean press: en 1 -> 0
        press(1'b0, e);
        hold_until(e + 100);
        btn_raw = 1'b0;
        hold_until(cyc + 50);
        check("press2_missing_pulse", exp_q.size(), 0);
        check("press2_en", int'(en), 0);

        // Bounce: toggle every 5 cycles for 60 cycles, settle at 0
        for (int i = 0; i < 12; i++) begin
            btn_raw = ~btn_raw;
            hold_until(cyc + 5);
            check("bounce_btn_db", int'(btn_db), 0);
        end
        hold_until(cyc + 40);
        check("bounce_final_db", int'(btn_db), 0);
        check("bounce_en", int'(en), 0);

        // One-cycle glitch that lands exactly on a sample
        while (cyc % SD != SD - 3) begin
            @(posedge clk);
            #1;
        end
        btn_raw = 1'b1;
        g = cyc + 3;
        @(posedge clk); #1;
        btn_raw = 1'b0;
        wait_cyc(g);
        check("glitch_sampled", int'(dut.u_debounce.shreg), 1);
        @(posedge clk); #1;
        hold_until(cyc + 40);
        check("glitch_btn_db", int'(btn_db), 0);
        check("glitch_flushed", int'(dut.u_debounce.shreg), 0);
        check("glitch_en", int'(en), 0);

        // Follow mode: en trails btn_db by one cycle, pulse still produced
        mode = 1'b1;
        hold_until(cyc + 3);
        check("follow_idle_en", int'(en), 0);
        press(1'b1, e);
        p = pulse_at(e);
        wait_cyc(p - 1);
        check("follow_rise_db", int'(btn_db), 1);
        check("follow_rise_en_late", int'(en), 0);
        wait_cyc(p);
        check("follow_rise_en", int'(en), 1);
        @(posedge clk); #1;
        hold_until(e + 80);
        btn_raw = 1'b0;
        e = cyc;
        p = db_at(e);
        wait_cyc(p);
        check("follow_fall_db", int'(btn_db), 0);
        check("follow_fall_en_late", int'(en), 1);
        wait_cyc(p + 1);
        check("follow_fall_en", int'(en), 0);
        @(posedge clk); #1;
        hold_until(cyc + 5);
        check("follow_missing_pulse", exp_q.size(), 0);

        // Mode switches
        mode = 1'b0;
        hold_until(cyc + 3);
        check("switch_1to0_en", int'(en), 0);
        press(1'b1, e);
        hold_until(e + 60);
        btn_raw = 1'b0;
        hold_until(cyc + 45);
        check("switch_setup_en", int'(en), 1);
        check("switch_setup_db", int'(btn_db), 0);
        mode = 1'b1;
        @(negedge clk);
        check("switch_before_edge_en", int'(en), 1);
        @(negedge clk);
        check("switch_0to1_en", int'(en), 0);
        @(posedge clk); #1;
        mode = 1'b0;
        hold_until(cyc + 5);
        check("switch_back_en", int'(en), 0);
        check("switch_missing_pulse", exp_q.size(), 0);

        // Reset mid-press: async clear, then a fresh pulse for the held button
        press(1'b1, e);
        p = pulse_at(e);
        hold_until(p + 3);
        check("prereset_en", int'(en), 1);
        check("prereset_db", int'(btn_db), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_en", int'(en), 0);
        check("async_rst_en_pulse", int'(en_pulse), 0);
        check("async_rst_btn_db", int'(btn_db), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        begin
            exp_t t;
            t.en  = 1'b1;
            t.cyc = pulse_at(0);
            exp_q.push_back(t);
        end
        hold_until(40);
        check("postreset_missing_pulse", exp_q.size(), 0);
        check("postreset_en", int'(en), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_en_conditioner
`default_nettype wire
